// File: rtl/imgproc_msg_reader.sv
// -----------------------------------------------------------------------------
// imgproc_msg_reader
//
// Avalon-MM master that sits directly downstream of the image-processing
// core's memory-mapped slave. It polls the slave status register, drains the
// 32-bit message FIFO one word per two cycles and parses the message stream:
//
//    0xAAAAAAAA, 6 colour-bound words, 0xBBBBBBBB, 15 edge words
//
// Each complete frame is published as latched parallel results together with
// a one-cycle res_valid strobe, so motor control or telemetry logic can use
// the vision results without CPU involvement.
//
// Ports
//    clk          system clock
//    reset_n      asynchronous active-low reset
//    m_chipselect slave select, high for exactly one cycle per access
//    m_read       read strobe, never high in two consecutive cycles
//    m_write      write strobe, used only for the FIFO flush command
//    m_address    word address: 0 = status, 1 = message
//    m_writedata  write data (flush command 0x00000010)
//    m_readdata   registered slave read data, valid the cycle after m_read
//    flush_req    pulse: flush the slave FIFO and resync the parser
//    res_valid    one-cycle pulse when res_colour / res_edges update
//    res_colour   6 x {min[10:0], max[10:0]}, colour 0 in [21:0]
//                 (red, green, blue, lime, yellow, pink)
//    res_edges    30 x 11-bit edge x-coordinates, edge 0 in [10:0]
//    sync_errors  saturating count of discarded or malformed words
//    busy         high whenever the transfer FSM is not in WAIT_POLL
// -----------------------------------------------------------------------------
module imgproc_msg_reader #(
   parameter int POLL_INTERVAL = 1024,
   parameter int ERR_W         = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   output logic             m_chipselect,
   output logic             m_read,
   output logic             m_write,
   output logic [2:0]       m_address,
   output logic [31:0]      m_writedata,
   input  logic [31:0]      m_readdata,
   input  logic             flush_req,
   output logic             res_valid,
   output logic [131:0]     res_colour,
   output logic [329:0]     res_edges,
   output logic [ERR_W-1:0] sync_errors,
   output logic             busy
);

   // The poll counter only ever holds 0 .. POLL_INTERVAL-1.
   localparam int PW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
   localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_INTERVAL - 1);

   localparam logic [31:0] HDR_A     = 32'hAAAA_AAAA;
   localparam logic [31:0] HDR_B     = 32'hBBBB_BBBB;
   localparam logic [31:0] FLUSH_CMD = 32'h0000_0010;

   typedef enum logic [2:0] {
      WAIT_POLL,
      RD_STATUS,
      CAP_STATUS,
      RD_MSG,
      CAP_MSG,
      FLUSH
   } xfer_state_t;

   typedef enum logic [1:0] {
      HUNT_A,
      COLOUR,
      HUNT_B,
      EDGE
   } parse_state_t;

   xfer_state_t  state;
   parse_state_t pstate;

   logic [PW-1:0] poll_cnt;
   logic [7:0]    cnt;
   logic          flush_pend;

   logic [3:0]    idx;
   logic [131:0]  sh_colour;
   logic [329:0]  sh_edges;
   logic          publish;

   logic flush_go;
   logic flush_start;
   logic word_take;
   logic word_ok;
   logic word_is_a;
   logic word_is_b;
   logic err_hit;

   // A flush is only launched from a cycle that is not the strobe cycle of a
   // read, so the bus always sees an idle gap between a read and the write.
   // A message word sitting in CAP_MSG while the flush launches is dropped
   // instead of being handed to the parser.
   always_comb begin
      flush_go    = flush_pend | flush_req;
      flush_start = flush_go && ((state == WAIT_POLL) ||
                                 (state == CAP_STATUS) ||
                                 (state == CAP_MSG));
      word_take   = (state == CAP_MSG) && !flush_go;
      word_ok     = (m_readdata[31:27] == 5'd0) && (m_readdata[15:11] == 5'd0);
      word_is_a   = (m_readdata == HDR_A);
      word_is_b   = (m_readdata == HDR_B);
      err_hit     = 1'b0;
      if (word_take) begin
         case (pstate)
            HUNT_A:  err_hit = !word_is_a;
            HUNT_B:  err_hit = !word_is_b;
            default: err_hit = !word_ok;
         endcase
      end
   end

   assign busy = (state != WAIT_POLL);

   // Transfer FSM. Bus outputs are registered: they are set on the edge that
   // enters the access cycle and cleared by default on the following edge,
   // which guarantees single-cycle strobes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= WAIT_POLL;
         poll_cnt     <= POLL_RELOAD;
         cnt          <= 8'd0;
         flush_pend   <= 1'b0;
         m_chipselect <= 1'b0;
         m_read       <= 1'b0;
         m_write      <= 1'b0;
         m_address    <= 3'd0;
         m_writedata  <= 32'd0;
      end else begin
         m_chipselect <= 1'b0;
         m_read       <= 1'b0;
         m_write      <= 1'b0;
         m_address    <= 3'd0;
         m_writedata  <= 32'd0;
         if (flush_req) begin
            flush_pend <= 1'b1;
         end
         if (flush_start) begin
            state        <= FLUSH;
            m_chipselect <= 1'b1;
            m_write      <= 1'b1;
            m_writedata  <= FLUSH_CMD;
            cnt          <= 8'd0;
            poll_cnt     <= POLL_RELOAD;
            flush_pend   <= 1'b0;
         end else begin
            case (state)
               WAIT_POLL: begin
                  if (poll_cnt == '0) begin
                     state        <= RD_STATUS;
                     m_chipselect <= 1'b1;
                     m_read       <= 1'b1;
                  end else begin
                     poll_cnt <= poll_cnt - 1'b1;
                  end
               end
               RD_STATUS: state <= CAP_STATUS;
               CAP_STATUS: begin
                  cnt <= m_readdata[15:8];
                  if (m_readdata[15:8] == 8'd0) begin
                     state    <= WAIT_POLL;
                     poll_cnt <= POLL_RELOAD;
                  end else begin
                     state        <= RD_MSG;
                     m_chipselect <= 1'b1;
                     m_read       <= 1'b1;
                     m_address    <= 3'd1;
                  end
               end
               RD_MSG: state <= CAP_MSG;
               CAP_MSG: begin
                  cnt          <= cnt - 8'd1;
                  m_chipselect <= 1'b1;
                  m_read       <= 1'b1;
                  if (cnt == 8'd1) begin
                     state     <= RD_STATUS;
                     m_address <= 3'd0;
                  end else begin
                     state     <= RD_MSG;
                     m_address <= 3'd1;
                  end
               end
               FLUSH:   state <= WAIT_POLL;
               default: state <= WAIT_POLL;
            endcase
         end
      end
   end

   // Frame parser. Words land in a shadow copy; the visible results are only
   // refreshed from the shadow one cycle after the final edge word, so a
   // partial or aborted frame can never disturb them.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pstate      <= HUNT_A;
         idx         <= 4'd0;
         sh_colour   <= '0;
         sh_edges    <= '0;
         publish     <= 1'b0;
         res_valid   <= 1'b0;
         res_colour  <= '0;
         res_edges   <= '0;
         sync_errors <= '0;
      end else begin
         res_valid <= publish;
         publish   <= 1'b0;
         if (publish) begin
            res_colour <= sh_colour;
            res_edges  <= sh_edges;
         end
         if (err_hit && (sync_errors != {ERR_W{1'b1}})) begin
            sync_errors <= sync_errors + 1'b1;
         end
         if (flush_start) begin
            pstate    <= HUNT_A;
            idx       <= 4'd0;
            sh_colour <= '0;
            sh_edges  <= '0;
         end else if (word_take) begin
            case (pstate)
               HUNT_A: begin
                  if (word_is_a) begin
                     pstate <= COLOUR;
                     idx    <= 4'd0;
                  end
               end
               COLOUR: begin
                  if (word_ok) begin
                     for (int i = 0; i < 6; i++) begin
                        if (idx == 4'(i)) begin
                           sh_colour[22*i +: 22] <= {m_readdata[26:16], m_readdata[10:0]};
                        end
                     end
                     if (idx == 4'd5) begin
                        pstate <= HUNT_B;
                        idx    <= 4'd0;
                     end else begin
                        idx <= idx + 4'd1;
                     end
                  end else if (word_is_a) begin
                     idx <= 4'd0;
                  end else begin
                     pstate <= HUNT_A;
                  end
               end
               HUNT_B: begin
                  if (word_is_b) begin
                     pstate <= EDGE;
                     idx    <= 4'd0;
                  end else if (word_is_a) begin
                     pstate <= COLOUR;
                     idx    <= 4'd0;
                  end else begin
                     pstate <= HUNT_A;
                  end
               end
               EDGE: begin
                  if (word_ok) begin
                     // Upper field is the even edge, lower field the odd one.
                     for (int i = 0; i < 15; i++) begin
                        if (idx == 4'(i)) begin
                           sh_edges[22*i +: 22] <= {m_readdata[10:0], m_readdata[26:16]};
                        end
                     end
                     if (idx == 4'd14) begin
                        pstate  <= HUNT_A;
                        idx     <= 4'd0;
                        publish <= 1'b1;
                     end else begin
                        idx <= idx + 4'd1;
                     end
                  end else if (word_is_a) begin
                     pstate <= COLOUR;
                     idx    <= 4'd0;
                  end else begin
                     pstate <= HUNT_A;
                  end
               end
               default: pstate <= HUNT_A;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imgproc_msg_reader.sv
// -----------------------------------------------------------------------------
// tb_imgproc_msg_reader
//
// Bench for imgproc_msg_reader. A queue-based slave model answers status and
// message reads and honours the flush command. A frame model consumes every
// popped message word (unless the flush that follows drops it) and keeps the
// list of accepted words since the last header; from that it predicts the
// published frames and the sync error count. Directed frames pin the model
// with hand-computed values, then randomized traffic runs against it.
// -----------------------------------------------------------------------------
module tb_imgproc_msg_reader;

   localparam int P  = 12;
   localparam int EW = 5;
   localparam logic [31:0] HDR_A = 32'hAAAA_AAAA;
   localparam logic [31:0] HDR_B = 32'hBBBB_BBBB;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          m_chipselect;
   logic          m_read;
   logic          m_write;
   logic [2:0]    m_address;
   logic [31:0]   m_writedata;
   logic [31:0]   m_readdata = 32'h0;
   logic          flush_req = 1'b0;
   logic          res_valid;
   logic [131:0]  res_colour;
   logic [329:0]  res_edges;
   logic [EW-1:0] sync_errors;
   logic          busy;

   always #5 clk = ~clk;

   imgproc_msg_reader #(.POLL_INTERVAL(P), .ERR_W(EW)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .m_chipselect (m_chipselect),
      .m_read       (m_read),
      .m_write      (m_write),
      .m_address    (m_address),
      .m_writedata  (m_writedata),
      .m_readdata   (m_readdata),
      .flush_req    (flush_req),
      .res_valid    (res_valid),
      .res_colour   (res_colour),
      .res_edges    (res_edges),
      .sync_errors  (sync_errors),
      .busy         (busy)
   );

   int n_vec = 0;
   int n_fail = 0;

   // Slave model: status reports the FIFO fill in [15:8], each message read
   // pops one word, a write of bit 4 to address 0 empties the FIFO.
   logic [31:0] fifo[$];

   always @(posedge clk) begin
      if (m_chipselect && m_read) begin
         if (m_address == 3'd0) begin
            m_readdata <= {16'h0, (fifo.size() > 255) ? 8'd255 : 8'(fifo.size()), 8'h00};
         end else if (fifo.size() > 0) begin
            m_readdata <= fifo.pop_front();
         end else begin
            m_readdata <= 32'h0;
         end
      end
      if (m_chipselect && m_write && (m_address == 3'd0) && m_writedata[4]) begin
         fifo.delete();
      end
   end

   // Frame model state.
   logic [31:0]  cur[$];
   logic [461:0] exp_q[$];
   int           exp_err = 0;
   logic [131:0] exp_colour = '0;
   logic [329:0] exp_edges = '0;

   bit          p1_v = 0, p2_v = 0, prev_read = 0, idle_mode = 0;
   logic [31:0] p1_w = 0, p2_w = 0;
   int          n_cyc = 0, last_stat = -1, n_pulse = 0, n_write = 0, n_msg = 0, n_stat = 0;

   task automatic check_output(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic bit fields_ok(input logic [31:0] w);
      return (w[31:27] == 5'd0) && (w[15:11] == 5'd0);
   endfunction

   task automatic bump_err();
      if (exp_err < (1 << EW) - 1) exp_err++;
   endtask

   task automatic publish_frame();
      logic [131:0] c;
      logic [329:0] e;
      for (int i = 0; i < 6; i++) c[22*i +: 22] = {cur[1+i][26:16], cur[1+i][10:0]};
      for (int j = 0; j < 15; j++) begin
         e[22*j +: 11]      = cur[8+j][26:16];
         e[22*j + 11 +: 11] = cur[8+j][10:0];
      end
      exp_q.push_back({e, c});
   endtask

   // cur holds the accepted words of the frame in progress: index 0 is the
   // A header, 1..6 colours, 7 the B header, 8..22 edges.
   task automatic model_word(input logic [31:0] w);
      int n = cur.size();
      if (n == 0) begin
         if (w == HDR_A) cur.push_back(w);
         else bump_err();
      end else if (n == 7) begin
         if (w == HDR_B) cur.push_back(w);
         else begin
            bump_err();
            cur.delete();
            if (w == HDR_A) cur.push_back(w);
         end
      end else if (fields_ok(w)) begin
         cur.push_back(w);
         if (cur.size() == 23) begin
            publish_frame();
            cur.delete();
         end
      end else begin
         bump_err();
         cur.delete();
         if (w == HDR_A) cur.push_back(w);
      end
   endtask

   // Compare process: bus protocol every cycle, frame contents on every
   // res_valid, counters and held results whenever the reader is idle.
   always @(negedge clk) begin
      if (!reset_n) begin
         cur.delete();
         exp_q.delete();
         exp_err    = 0;
         exp_colour = '0;
         exp_edges  = '0;
         p1_v       = 0;
         p2_v       = 0;
         prev_read  = 0;
         last_stat  = -1;
      end else begin
         n_cyc++;
         if (p2_v && !m_write) model_word(p2_w);
         if (m_write) begin
            n_write++;
            cur.delete();
            check_output("flush write", {m_chipselect, m_read, m_address, m_writedata},
                         {1'b1, 1'b0, 3'd0, 32'h10});
            check_output("write after read", prev_read, 0);
         end
         p2_v = p1_v;
         p2_w = p1_w;
         p1_v = m_read && (m_address == 3'd1);
         p1_w = (fifo.size() > 0) ? fifo[0] : 32'h0;
         if (m_read) begin
            check_output("read strobe", {m_chipselect, m_write, busy, prev_read}, 4'b1010);
            if (m_address == 3'd0) begin
               n_stat++;
               if (idle_mode && last_stat >= 0) check_output("poll spacing", n_cyc - last_stat, P + 2);
               last_stat = n_cyc;
            end else begin
               n_msg++;
               if (idle_mode) check_output("idle address", m_address, 0);
            end
         end
         if (!m_read && !m_write) check_output("idle chipselect", m_chipselect, 0);
         if (res_valid) begin
            n_pulse++;
            if (exp_q.size() == 0) begin
               check_output("spurious res_valid", res_valid, 0);
            end else begin
               logic [461:0] x;
               x = exp_q.pop_front();
               exp_colour = x[131:0];
               exp_edges  = x[461:132];
               check_output("res_colour", res_colour, exp_colour);
               check_output("res_edges", res_edges, exp_edges);
            end
         end
         if (!busy) begin
            check_output("sync_errors", sync_errors, exp_err);
            check_output("res_colour hold", res_colour, exp_colour);
            check_output("res_edges hold", res_edges, exp_edges);
         end
         prev_read = m_read;
      end
   end

   // Stimulus helpers. All pushes happen 2 time units after a rising edge.
   logic [31:0] frm[$];

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic apply_stimulus(input logic [31:0] w);
      fifo.push_back(w);
   endtask

   task automatic send_frm();
      foreach (frm[k]) apply_stimulus(frm[k]);
   endtask

   // fixed=1: colour i = min 40+i, max 100+i; edge words carry 2j+1 / 2j+2.
   task automatic build_frame(input bit fixed);
      frm.delete();
      frm.push_back(HDR_A);
      for (int i = 0; i < 6; i++)
         frm.push_back(fixed ? {5'd0, 11'(40 + i), 5'd0, 11'(100 + i)}
                             : {5'd0, 11'($urandom), 5'd0, 11'($urandom)});
      frm.push_back(HDR_B);
      for (int j = 0; j < 15; j++)
         frm.push_back(fixed ? {5'd0, 11'(2*j + 1), 5'd0, 11'(2*j + 2)}
                             : {5'd0, 11'($urandom), 5'd0, 11'($urandom)});
   endtask

   task automatic pulse_flush();
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      repeat (4) tick();
   endtask

   task automatic wait_idle(input string nm);
      int k = 0;
      do begin
         tick();
         k++;
      end while (!(fifo.size() == 0 && !busy) && k < 3000);
      if (k >= 3000) begin
         n_vec++;
         n_fail++;
         $display("[TB] FAIL %s timeout: busy=%0b fifo=%0d, expected drained", nm, busy, fifo.size());
      end
      repeat (3) tick();
   endtask

   task automatic wait_msg_reads(input int target);
      int k = 0;
      while (n_msg < target && k < 2000) begin
         tick();
         k++;
      end
      check_output("message reads reached", n_msg >= target, 1);
   endtask

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation time exhausted");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int base;
      reset_n   = 1'b0;
      flush_req = 1'b0;
      repeat (3) tick();
      check_output("reset outputs",
                   {m_chipselect, m_read, m_write, m_address, m_writedata, res_valid,
                    res_colour, res_edges, sync_errors, busy}, 0);
      reset_n = 1'b1;

      // Empty slave: only status polls, P+2 apart.
      idle_mode = 1;
      repeat (5 * (P + 2)) tick();
      idle_mode = 0;
      check_output("idle message reads", n_msg, 0);
      check_output("idle polls seen", n_stat >= 4, 1);

      // Clean frame.
      base = n_msg;
      build_frame(1);
      send_frm();
      wait_idle("clean frame");
      check_output("clean msg reads", n_msg - base, 23);
      check_output("clean red", res_colour[21:0], {11'd40, 11'd100});
      check_output("clean edge0", res_edges[10:0], 11'd1);
      check_output("clean edge1", res_edges[21:11], 11'd2);
      check_output("clean pink", res_colour[131:110], {11'd45, 11'd105});
      check_output("clean errors", sync_errors, 0);
      check_output("clean pulses", n_pulse, 1);

      // Junk in front of a frame.
      apply_stimulus(32'h1234_5678);
      apply_stimulus(HDR_B);
      build_frame(1);
      send_frm();
      wait_idle("junk frame");
      check_output("junk errors", sync_errors, 2);
      check_output("junk pulses", n_pulse, 2);

      // Malformed colour word 3: 1 + 18 trailing words hunted over.
      build_frame(1);
      frm[4] = 32'hFFFF_0000;
      send_frm();
      wait_idle("bad colour");
      check_output("bad colour errors", sync_errors, 21);
      check_output("bad colour pulses", n_pulse, 2);
      check_output("bad colour hold", res_colour[21:0], {11'd40, 11'd100});
      build_frame(1);
      send_frm();
      wait_idle("recovery frame");
      check_output("recovery pulses", n_pulse, 3);

      // Header arriving at colour index 4 restarts the frame.
      build_frame(1);
      for (int k = 0; k < 5; k++) apply_stimulus(frm[k]);
      send_frm();
      wait_idle("early header");
      check_output("early header errors", sync_errors, 22);
      check_output("early header pulses", n_pulse, 4);

      // Flush in the middle of a drain.
      base = n_write;
      build_frame(1);
      send_frm();
      wait_msg_reads(n_msg + 5);
      pulse_flush();
      wait_idle("flush");
      check_output("flush writes", n_write - base, 1);
      check_output("flush errors", sync_errors, 22);
      check_output("flush pulses", n_pulse, 4);
      build_frame(0);
      send_frm();
      wait_idle("post flush frame");
      check_output("post flush pulses", n_pulse, 5);

      // Randomized traffic.
      for (int it = 0; it < 40; it++) begin
         int kind = $urandom_range(0, 4);
         case (kind)
            0, 1: begin
               build_frame(0);
               send_frm();
            end
            2: begin
               int pos = $urandom_range(1, 22);
               build_frame(0);
               frm[pos] = ($urandom_range(0, 2) == 0) ? HDR_A : $urandom;
               send_frm();
            end
            3: begin
               repeat ($urandom_range(1, 3)) begin
                  case ($urandom_range(0, 3))
                     0: apply_stimulus(HDR_A);
                     1: apply_stimulus(HDR_B);
                     2: apply_stimulus($urandom);
                     default: apply_stimulus({5'd0, 11'($urandom), 5'd0, 11'($urandom)});
                  endcase
               end
            end
            default: begin
               build_frame(0);
               for (int k = 0; k < $urandom_range(1, 22); k++) apply_stimulus(frm[k]);
            end
         endcase
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(0, 50)) tick();
            pulse_flush();
         end
         wait_idle("random");
      end

      // Error counter saturation.
      repeat (40) apply_stimulus(32'h1234_5678);
      wait_idle("saturation");
      check_output("saturated errors", sync_errors, 5'h1F);

      // Asynchronous reset during a message read.
      build_frame(1);
      send_frm();
      begin
         int k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (!(m_read && m_address == 3'd1) && k < 2000);
         check_output("read before reset", m_read && (m_address == 3'd1), 1);
      end
      #2 reset_n = 1'b0;
      #1;
      check_output("async reset outputs",
                   {m_chipselect, m_read, m_write, m_address, m_writedata, res_valid,
                    res_colour, res_edges, sync_errors, busy}, 0);
      fifo.delete();
      tick();
      tick();
      reset_n = 1'b1;
      repeat (2 * (P + 2)) tick();
      check_output("pending frames", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
